pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives hold and bubble controls for the F->D, D->EX and EX->MEM pipeline registers.
- Sources: load-use hazards (D vs EX), taken branches resolved in EX, and multi-cycle data-memory waits in MEM.
- Its `bubble_EX` output drives the `stall_D` (clear) input of the D->EX register.

Parameters:
- `LD_LAT`, 1: bubble cycles inserted per load-use hazard (1..7).
- `MEM_TIMEOUT`, 255: max MEMWAIT cycles before `mem_err` pulses (1..65535).

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `D_rs1`  in  5  source reg 1 of instruction in D
- `D_rs2`  in  5  source reg 2 of instruction in D
- `D_use_rs1`  in  1  D instruction reads rs1
- `D_use_rs2`  in  1  D instruction reads rs2
- `EX_rd`  in  5  destination reg of instruction in EX
- `EX_ld`  in  1  instruction in EX is a load
- `EX_brn_taken`  in  1  branch in EX resolved taken this cycle
- `MEM_req`  in  1  instruction in MEM is a load/store
- `MEM_ready`  in  1  data memory completes the MEM access this cycle
- `stall_F`  out  1  hold PC
- `hold_D`  out  1  hold F->D register
- `flush_D`  out  1  clear F->D register (insert NOP)
- `bubble_EX`  out  1  clear D->EX register
- `hold_EX`  out  1  hold D->EX and EX->MEM registers
- `mem_err`  out  1  one-cycle pulse: memory wait exceeded `MEM_TIMEOUT`

Behaviour:
- **Registered state:**
  - 2-bit FSM: RUN, LDUSE, MEMWAIT.
  - 3-bit `ld_cnt`, 16-bit `wait_cnt`, registered `mem_err`.
- **Combinational outputs:** all outputs except `mem_err` are functions of current state and inputs (same-cycle effect).
- **Reset:**
  - State RUN, counters 0.
  - `mem_err`=0.
  - All combinational outputs evaluate to 0 when no hazard inputs are active.
  - `rst` mid-stall aborts immediately; the next cycle is RUN.
- **Hazard definition:** `haz` = `EX_ld` & `EX_rd`!=0 & ((`D_use_rs1` & `D_rs1`==`EX_rd`) | (`D_use_rs2` & `D_rs2`==`EX_rd`)). Register x0 never hazards.
- **Priority** (highest first): `rst` > memory wait > branch flush > load-use.
- **Memory wait:** `mw` = `MEM_req` & !`MEM_ready`.
  - In any state, `mw` forces `stall_F`=`hold_D`=`hold_EX`=1 and `flush_D`=`bubble_EX`=0 (full freeze).
  - State -> MEMWAIT.
- **RUN:**
  - If `mw`: freeze as above, `wait_cnt`<=1, -> MEMWAIT.
  - Else if `EX_brn_taken`: `flush_D`=1, `bubble_EX`=1; stay RUN.
  - Else if `haz`: `stall_F`=1, `hold_D`=1, `bubble_EX`=1.
    - If `LD_LAT`==1: stay RUN.
    - Else: `ld_cnt`<=`LD_LAT`-1, -> LDUSE.
  - Else: all 0.
- **LDUSE:**
  - Outputs `stall_F`=`hold_D`=`bubble_EX`=1; `ld_cnt` decrements each cycle.
  - Exit to RUN when `ld_cnt`==1 (that cycle still stalls).
  - `EX_brn_taken` in LDUSE cannot occur (EX holds a bubble) and is ignored.
- **MEMWAIT:**
  - Freeze while `mw`; `wait_cnt` increments, saturating at 0xFFFF.
  - When `wait_cnt`==`MEM_TIMEOUT` and `mw` still asserted: `mem_err`=1 for exactly one cycle, `wait_cnt` resets to 0, freeze continues.
  - When `MEM_ready`=1 (or `MEM_req`=0): outputs for that cycle are evaluated exactly as in RUN (branch/haz may act), `wait_cnt`<=0.
    - Next state is LDUSE if a load-use hazard with `LD_LAT`>1 is taken that cycle.
    - Otherwise next state is RUN.
  - `ld_cnt` is preserved across MEMWAIT: if entered from LDUSE, return to LDUSE with the remaining count.
- **Simultaneous `haz` and `EX_brn_taken`:** branch wins. No stall; flush only.
- `MEM_req`=1 with `MEM_ready`=1 in the same cycle: no stall (single-cycle access).

Optional Feature:
- Macro: `PIPE_HAZARD_PERF_EN`.
- **When defined:**
  - Adds outputs `perf_ld_stalls` (32) and `perf_mem_stalls` (32).
  - Counters increment on each cycle with load-use stall, or memory freeze, respectively.
  - Cleared by `rst`; wrap at 2^32.
- **When undefined:** ports and counters are absent. Core behaviour is identical.

Test Plan:
- `EX_ld`=1, `EX_rd`=5, `D_rs1`=5, `D_use_rs1`=1, `LD_LAT`=1 -> one cycle `stall_F`=`hold_D`=`bubble_EX`=1, then all 0. Same stimulus with `EX_rd`=0 -> no stall.
- `LD_LAT`=3, hazard on rs2=7 -> exactly 3 consecutive stall cycles, state back to RUN on the 4th.
- Hazard and `EX_brn_taken` in the same cycle -> `flush_D`=1, `bubble_EX`=1, `stall_F`=0, no LDUSE entry.
- `MEM_req`=1, `MEM_ready` low for 4 cycles then high -> `stall_F`/`hold_D`/`hold_EX`=1 for exactly 4 cycles, `mem_err` never pulses. With `MEM_TIMEOUT`=3 and 10 wait cycles -> `mem_err` pulses on wait cycles 3, 6 and 9.
- `LD_LAT`=3 and memory wait of 2 cycles begins during LDUSE -> freeze 2 cycles, then remaining load-use stall cycles complete (total bubble count 3).
- `rst` asserted during MEMWAIT -> next cycle all outputs 0, state RUN, `perf_*`=0 when `PIPE_HAZARD_PERF_EN` is defined.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central stall/flush controller for a 5-stage pipeline. It steers the hold and
// bubble controls of the F->D, D->EX and EX->MEM pipeline registers from three
// hazard sources: load-use (D vs EX), taken branches resolved in EX and
// multi-cycle data-memory waits in MEM.
// Priority, highest first: rst > memory wait > branch flush > load-use.
//
// Parameters:
//   LD_LAT       bubble cycles per load-use hazard (1..7)
//   MEM_TIMEOUT  memory wait cycles per mem_err pulse (1..65535)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   D_rs1/D_rs2              source registers of the instruction in D
//   D_use_rs1/D_use_rs2      D instruction really reads rs1/rs2
//   EX_rd, EX_ld             destination register / load flag of EX instruction
//   EX_brn_taken             branch in EX resolved taken this cycle
//   MEM_req, MEM_ready       MEM access present / completing this cycle
//   stall_F                  hold PC                       (combinational)
//   hold_D                   hold F->D register            (combinational)
//   flush_D                  clear F->D register           (combinational)
//   bubble_EX                clear D->EX register          (combinational)
//   hold_EX                  hold D->EX and EX->MEM        (combinational)
//   mem_err                  one-cycle pulse on wait timeout (registered)
//
// Optional build macro PIPE_HAZARD_PERF_EN adds two 32-bit wrapping counters:
//   perf_ld_stalls           cycles spent in a load-use stall
//   perf_mem_stalls          cycles spent in a memory freeze
module pipe_hazard_ctrl #(
  parameter int unsigned LD_LAT      = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs1,
  input  logic [4:0]  D_rs2,
  input  logic        D_use_rs1,
  input  logic        D_use_rs2,
  input  logic [4:0]  EX_rd,
  input  logic        EX_ld,
  input  logic        EX_brn_taken,
  input  logic        MEM_req,
  input  logic        MEM_ready,
  output logic        stall_F,
  output logic        hold_D,
  output logic        flush_D,
  output logic        bubble_EX,
  output logic        hold_EX,
  output logic        mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_ld_stalls,
  output logic [31:0] perf_mem_stalls
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [2:0]  LD_RELOAD = 3'(LD_LAT - 1);
  localparam logic [15:0] TMO       = 16'(MEM_TIMEOUT);
  localparam bit          MULTI_LD  = (LD_LAT > 1);

  state_t      state, state_nxt;
  logic [2:0]  ld_cnt, ld_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic        mem_err_nxt;
  logic        haz, mw;

  // Hazard detection; x0 is hard-wired zero and never creates a dependency.
  always_comb begin
    haz = EX_ld & (EX_rd != 5'd0) &
          ((D_use_rs1 & (D_rs1 == EX_rd)) | (D_use_rs2 & (D_rs2 == EX_rd)));
    mw  = MEM_req & ~MEM_ready;
    wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : (wait_cnt + 16'd1);
  end

  // Next-state and stall/flush outputs.
  always_comb begin
    stall_F      = 1'b0;
    hold_D       = 1'b0;
    flush_D      = 1'b0;
    bubble_EX    = 1'b0;
    hold_EX      = 1'b0;
    state_nxt    = state;
    ld_cnt_nxt   = ld_cnt;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = 1'b0;

    if (rst) begin
      state_nxt    = RUN;
      ld_cnt_nxt   = 3'd0;
      wait_cnt_nxt = 16'd0;
    end else if (mw) begin
      // Full freeze. ld_cnt is left untouched so an interrupted load-use
      // stall resumes with its remaining count once memory completes.
      stall_F   = 1'b1;
      hold_D    = 1'b1;
      hold_EX   = 1'b1;
      state_nxt = MEMWAIT;
      if (wait_inc == TMO) begin
        mem_err_nxt  = 1'b1;
        wait_cnt_nxt = 16'd0;
      end else begin
        wait_cnt_nxt = wait_inc;
      end
    end else begin
      wait_cnt_nxt = 16'd0;
      // A pending load-use count (LDUSE, or MEMWAIT entered from LDUSE) keeps
      // stalling and ignores branches: EX holds a bubble in that window.
      if ((state == LDUSE) || ((state == MEMWAIT) && (ld_cnt != 3'd0))) begin
        stall_F    = 1'b1;
        hold_D     = 1'b1;
        bubble_EX  = 1'b1;
        ld_cnt_nxt = (ld_cnt == 3'd0) ? 3'd0 : (ld_cnt - 3'd1);
        state_nxt  = (ld_cnt <= 3'd1) ? RUN : LDUSE;
      end else if (EX_brn_taken) begin
        flush_D   = 1'b1;
        bubble_EX = 1'b1;
        state_nxt = RUN;
      end else if (haz) begin
        stall_F   = 1'b1;
        hold_D    = 1'b1;
        bubble_EX = 1'b1;
        if (MULTI_LD) begin
          ld_cnt_nxt = LD_RELOAD;
          state_nxt  = LDUSE;
        end else begin
          state_nxt = RUN;
        end
      end else begin
        state_nxt = RUN;
      end
    end
  end

  // State, counters and the registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ld_cnt   <= 3'd0;
      wait_cnt <= 16'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_cnt   <= ld_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Performance counters; a load-use stall is the only stall that also bubbles EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_stalls  <= 32'd0;
      perf_mem_stalls <= 32'd0;
    end else begin
      if (stall_F & bubble_EX) begin
        perf_ld_stalls <= perf_ld_stalls + 32'd1;
      end else begin
        perf_ld_stalls <= perf_ld_stalls;
      end
      if (hold_EX) begin
        perf_mem_stalls <= perf_mem_stalls + 32'd1;
      end else begin
        perf_mem_stalls <= perf_mem_stalls;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Two instances share one input stream:
// dut_a (LD_LAT=3, MEM_TIMEOUT=3) and dut_b (LD_LAT=1, MEM_TIMEOUT=255).
// A driver issues one input vector per cycle and pushes the reference model's
// expected outputs into per-instance queues; a monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] D_rs1, D_rs2, EX_rd;
  logic       D_use_rs1, D_use_rs2, EX_ld, EX_brn_taken, MEM_req, MEM_ready;

  logic a_stall_F, a_hold_D, a_flush_D, a_bubble_EX, a_hold_EX, a_mem_err;
  logic b_stall_F, b_hold_D, b_flush_D, b_bubble_EX, b_hold_EX, b_mem_err;
  logic [31:0] a_pld, a_pmem, b_pld, b_pmem;

  pipe_hazard_ctrl #(.LD_LAT(3), .MEM_TIMEOUT(3)) dut_a (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .EX_rd(EX_rd), .EX_ld(EX_ld),
    .EX_brn_taken(EX_brn_taken), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
    .stall_F(a_stall_F), .hold_D(a_hold_D), .flush_D(a_flush_D),
    .bubble_EX(a_bubble_EX), .hold_EX(a_hold_EX), .mem_err(a_mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_ld_stalls(a_pld), .perf_mem_stalls(a_pmem)
`endif
  );

  pipe_hazard_ctrl #(.LD_LAT(1), .MEM_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .EX_rd(EX_rd), .EX_ld(EX_ld),
    .EX_brn_taken(EX_brn_taken), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
    .stall_F(b_stall_F), .hold_D(b_hold_D), .flush_D(b_flush_D),
    .bubble_EX(b_bubble_EX), .hold_EX(b_hold_EX), .mem_err(b_mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_ld_stalls(b_pld), .perf_mem_stalls(b_pmem)
`endif
  );

`ifndef PIPE_HAZARD_PERF_EN
  assign a_pld = 32'd0; assign a_pmem = 32'd0;
  assign b_pld = 32'd0; assign b_pmem = 32'd0;
`endif

  // outs = {stall_F, hold_D, flush_D, bubble_EX, hold_EX, mem_err}
  typedef struct packed {
    logic [5:0]  outs;
    logic [31:0] pld;
    logic [31:0] pmem;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state per instance: remaining load-use bubbles, length of
  // the current memory-wait run, pending error pulse, performance counts.
  int          pend_a = 0, nwait_a = 0, pend_b = 0, nwait_b = 0;
  logic        err_a = 1'b0, err_b = 1'b0;
  logic [31:0] pld_a = 32'd0, pmem_a = 32'd0, pld_b = 32'd0, pmem_b = 32'd0;

  task automatic model_step(input int lat, input int tmo,
                            inout int pend, inout int nwait, inout logic err,
                            inout logic [31:0] pld, inout logic [31:0] pmem,
                            output exp_t e);
    logic haz, mw, s, h, f, b, x, err_now;
    haz = EX_ld && (EX_rd != 5'd0) &&
          ((D_use_rs1 && D_rs1 == EX_rd) || (D_use_rs2 && D_rs2 == EX_rd));
    mw  = MEM_req && !MEM_ready;
    {s, h, f, b, x} = 5'b00000;
    err_now = err;
    e.pld   = pld;
    e.pmem  = pmem;
    if (rst) begin
      pend = 0; nwait = 0; err = 1'b0; pld = 32'd0; pmem = 32'd0;
    end else if (mw) begin
      s = 1'b1; h = 1'b1; x = 1'b1;
      nwait = nwait + 1;
      err   = ((nwait % tmo) == 0);
      pmem  = pmem + 32'd1;
    end else begin
      nwait = 0;
      err   = 1'b0;
      if (pend > 0) begin
        s = 1'b1; h = 1'b1; b = 1'b1; pend = pend - 1; pld = pld + 32'd1;
      end else if (EX_brn_taken) begin
        f = 1'b1; b = 1'b1;
      end else if (haz) begin
        s = 1'b1; h = 1'b1; b = 1'b1; pend = lat - 1; pld = pld + 32'd1;
      end
    end
    e.outs = {s, h, f, b, x, err_now};
  endtask

  // Apply one cycle of inputs (called just after a rising edge).
  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic req, input logic rdy);
    exp_t ea, eb;
    rst = r; D_rs1 = rs1; D_rs2 = rs2; D_use_rs1 = u1; D_use_rs2 = u2;
    EX_rd = rd; EX_ld = ld; EX_brn_taken = br; MEM_req = req; MEM_ready = rdy;
    model_step(3, 3,   pend_a, nwait_a, err_a, pld_a, pmem_a, ea);
    model_step(1, 255, pend_b, nwait_b, err_b, pld_b, pmem_b, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic memw(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, got, want);
    end
  endtask

  // Monitor: one output vector per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_outs", {26'd0, a_stall_F, a_hold_D, a_flush_D, a_bubble_EX, a_hold_EX, a_mem_err},
          {26'd0, ea.outs});
`ifdef PIPE_HAZARD_PERF_EN
      chk("a_perf_ld", a_pld, ea.pld);
      chk("a_perf_mem", a_pmem, ea.pmem);
`endif
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_outs", {26'd0, b_stall_F, b_hold_D, b_flush_D, b_bubble_EX, b_hold_EX, b_mem_err},
          {26'd0, eb.outs});
`ifdef PIPE_HAZARD_PERF_EN
      chk("b_perf_ld", b_pld, eb.pld);
      chk("b_perf_mem", b_pmem, eb.pmem);
`endif
    end
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rs1, rs2, rd;
    logic       req;
    rst = 1'b1; D_rs1 = 5'd0; D_rs2 = 5'd0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
    EX_rd = 5'd0; EX_ld = 1'b0; EX_brn_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset, then quiet pipeline
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs1=5, then the same with x0 as destination
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs2=7
    drive(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Hazard and taken branch together: branch wins
    drive(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Single-cycle access, 4-cycle wait, 10-cycle wait
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    memw(4);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    memw(10);
    idle(3);
    // Memory wait starting inside a load-use stall
    drive(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    memw(2);
    idle(4);
    // Wait exiting straight into a branch and into a hazard
    memw(2);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    memw(1);
    drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Reset in the middle of a memory wait
    memw(5);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      req = ($urandom_range(0, 99) < 35);
      drive(($urandom_range(0, 199) == 0), rs1, rs2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
            req, ($urandom_range(0, 99) < 35));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
